// File: rtl/mem_ctrl_pkg.sv
// Shared Avalon widths and the loader state encoding.
package mem_ctrl_pkg;

  localparam int unsigned AVL_DATA_W = 128;
  localparam int unsigned AVL_ADDR_W = 26;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRet,
    StPad,
    StDrain
  } load_state_t;

endpackage

// File: rtl/stride_addr_gen.sv
// Row/beat address walker: row base is accumulated by stride, beat offset is added on top.
module stride_addr_gen
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BEATS_PER_ROW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [AVL_ADDR_W-1:0] start_address,
  input  logic [9:0]            stride,
  input  logic [6:0]            eff_rows,
  input  logic                  advance,
  output logic [AVL_ADDR_W-1:0] address,
  output logic                  last
);

  localparam int unsigned BEAT_W = $clog2(BEATS_PER_ROW + 1);

  logic [AVL_ADDR_W-1:0] row_base_q;
  logic [9:0]            stride_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [6:0]            row_q;
  logic                  beat_last;

  assign beat_last = (beat_q == BEAT_W'(BEATS_PER_ROW - 1));
  assign address   = row_base_q + AVL_ADDR_W'(beat_q);
  assign last      = beat_last && ((row_q + 7'd1) == eff_rows);

  // Counters restart on load and step once per accepted command, row-major.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_q <= '0;
      stride_q   <= '0;
      beat_q     <= '0;
      row_q      <= '0;
    end else if (load) begin
      row_base_q <= start_address;
      stride_q   <= stride;
      beat_q     <= '0;
      row_q      <= '0;
    end else if (advance) begin
      if (beat_last) begin
        beat_q     <= '0;
        row_q      <= row_q + 7'd1;
        row_base_q <= row_base_q + AVL_ADDR_W'(stride_q);
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/strided_block_loader.sv
// Fetches a strided block of rows over Avalon-MM reads into a flat word array.
module strided_block_loader
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned COLS            = 8,
  parameter int unsigned MAX_ROWS        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             load_ddr,
  input  logic [AVL_ADDR_W-1:0]            start_address,
  input  logic [9:0]                       stride,
  input  logic [9:0]                       rows,
  input  logic                             pad,
  output logic                             ready,
  output logic [MAX_ROWS*COLS-1:0][31:0]   block,
  input  logic                             local_init_done,
  input  logic                             avl_wait_request_n,
  input  logic                             avl_readdatavalid,
  input  logic [AVL_DATA_W-1:0]            avl_readdata,
  output logic                             avl_read,
  output logic                             avl_burstbegin,
  output logic [AVL_ADDR_W-1:0]            avl_address,
  output logic                             avl_write,
  output logic [AVL_DATA_W-1:0]            avl_writedata
);

  localparam int unsigned BPR    = COLS / 4;
  localparam int unsigned NBEATS = MAX_ROWS * BPR;
  localparam int unsigned IDX_W  = $clog2(NBEATS + 1);

  load_state_t state_q, state_d;
  logic [3:0]       out_q, out_d;
  logic [6:0]       eff_rows_q, eff_rows_d, rows_clamped;
  logic             pad_q, pad_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [NBEATS-1:0][AVL_DATA_W-1:0] block_q;

  logic accept_load, issue_ok, cmd_accept, beat_valid, beat_write;
  logic blk_zero_all, blk_pad;
  logic [AVL_ADDR_W-1:0] gen_address;
  logic gen_last;

  assign rows_clamped = (rows > 10'(MAX_ROWS)) ? 7'(MAX_ROWS) : rows[6:0];
  assign accept_load  = (state_q == StIdle) && load_ddr && local_init_done && !clear;
  assign issue_ok     = (state_q == StIssue) && !clear && (out_q < 4'(MAX_OUTSTANDING));
  assign cmd_accept   = issue_ok && avl_wait_request_n;
  // Beats with nothing outstanding (e.g. stale after reset) are dropped.
  assign beat_valid   = avl_readdatavalid && (out_q != 4'd0);
  assign beat_write   = beat_valid && !clear && ((state_q == StIssue) || (state_q == StWaitRet));

  assign ready          = (state_q == StIdle);
  assign avl_read       = issue_ok;
  assign avl_burstbegin = issue_ok;
  assign avl_address    = (state_q == StIssue) ? gen_address : '0;
  assign avl_write      = 1'b0;
  assign avl_writedata  = '0;
  assign block          = block_q;

  stride_addr_gen #(
    .BEATS_PER_ROW(BPR)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load         (accept_load),
    .start_address(start_address),
    .stride       (stride),
    .eff_rows     (eff_rows_q),
    .advance      (cmd_accept),
    .address      (gen_address),
    .last         (gen_last)
  );

  // Outstanding count, load latches, FSM next state and block write controls.
  always_comb begin
    state_d      = state_q;
    eff_rows_d   = eff_rows_q;
    pad_d        = pad_q;
    wr_idx_d     = wr_idx_q;
    blk_zero_all = 1'b0;
    blk_pad      = 1'b0;

    unique case ({cmd_accept, beat_valid})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    if (beat_write) wr_idx_d = wr_idx_q + IDX_W'(1);

    case (state_q)
      StIdle: begin
        if (clear) begin
          blk_zero_all = 1'b1;
        end else if (accept_load) begin
          eff_rows_d = rows_clamped;
          pad_d      = pad;
          wr_idx_d   = '0;
          if (rows_clamped == 7'd0) state_d = pad ? StPad : StIdle;
          else                      state_d = StIssue;
        end
      end
      StIssue: begin
        if (clear)                      state_d = (out_d != 4'd0) ? StDrain : StIdle;
        else if (cmd_accept && gen_last) state_d = StWaitRet;
      end
      StWaitRet: begin
        if (clear) begin
          state_d = (out_d != 4'd0) ? StDrain : StIdle;
        end else if (beat_valid && (out_q == 4'd1)) begin
          state_d = (pad_q && (eff_rows_q < 7'(MAX_ROWS))) ? StPad : StIdle;
        end
      end
      StPad: begin
        if (clear) begin
          state_d = (out_d != 4'd0) ? StDrain : StIdle;
        end else begin
          blk_pad = 1'b1;
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (out_d == 4'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      out_q      <= '0;
      eff_rows_q <= '0;
      pad_q      <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      eff_rows_q <= eff_rows_d;
      pad_q      <= pad_d;
      wr_idx_q   <= wr_idx_d;
    end
  end

  // Block storage: one 4-word slot per beat; padding clears whole rows past eff_rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NBEATS; k++) begin
        if (blk_zero_all) begin
          block_q[k] <= '0;
        end else if (beat_write && (wr_idx_q == IDX_W'(k))) begin
          block_q[k] <= avl_readdata;
        end else if (blk_pad && ((k / BPR) >= 32'(eff_rows_q))) begin
          block_q[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_strided_block_loader.sv
// Directed bench: Avalon slave model, spec-level block/address model, per-cycle compare.
module tb_strided_block_loader;

  localparam int NW = 32;

  logic clk = 1'b0;
  logic reset, clear, load_ddr, pad, local_init_done;
  logic [25:0] start_address, avl_address;
  logic [9:0] stride, rows;
  logic ready, avl_read, avl_burstbegin, avl_write;
  logic avl_wait_request_n, avl_readdatavalid;
  logic [127:0] avl_readdata, avl_writedata;
  logic [NW-1:0][31:0] block;

  int checks = 0, errors = 0;
  int cyc = 0, accepted_cnt = 0, returned_cnt = 0, max_out = 0, last_ret_cyc = 0;
  int wait_cycles = 0, latency = 2, wait_ctr = 0;
  logic [25:0] exp_addr_q[$];
  logic [25:0] obs_addr_q[$];
  int          ret_due_q[$];
  logic [25:0] ret_addr_q[$];
  logic [NW-1:0][31:0] exp_blk;
  logic prev_wait = 1'b0;
  logic [25:0] prev_addr = '0;

  logic [25:0] lit_basic [8] = '{26'h100, 26'h101, 26'h120, 26'h121,
                                 26'h140, 26'h141, 26'h160, 26'h161};
  logic [25:0] lit_wrap  [4] = '{26'h3FFFFFF, 26'h0, 26'h0, 26'h1};

  strided_block_loader #(
    .COLS(8), .MAX_ROWS(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .load_ddr(load_ddr),
    .start_address(start_address), .stride(stride), .rows(rows), .pad(pad),
    .ready(ready), .block(block), .local_init_done(local_init_done),
    .avl_wait_request_n(avl_wait_request_n), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .avl_read(avl_read), .avl_burstbegin(avl_burstbegin),
    .avl_address(avl_address), .avl_write(avl_write), .avl_writedata(avl_writedata)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] beat_data(input logic [25:0] a);
    logic [127:0] d;
    for (int j = 0; j < 4; j++) d[32*j +: 32] = {4'hA, 2'(j), a};
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_block(input string name);
    int bad = -1;
    for (int i = 0; i < NW; i++) if (bad < 0 && block[i] !== exp_blk[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %0h, expected %0h", name, bad, block[bad], exp_blk[bad]);
    end
  endtask

  // Model: address = start + r*stride + b (mod 2^26); beat k fills words 4k..4k+3.
  task automatic build_model(input logic [25:0] sa, input logic [9:0] st, input int nrows,
                             input logic pd, output int eff);
    logic [25:0] a;
    eff = (nrows > 4) ? 4 : nrows;
    exp_addr_q.delete();
    obs_addr_q.delete();
    for (int r = 0; r < eff; r++) begin
      for (int b = 0; b < 2; b++) begin
        a = sa + 26'(r * int'(st)) + 26'(b);
        exp_addr_q.push_back(a);
        for (int j = 0; j < 4; j++) exp_blk[(r*2+b)*4+j] = {4'hA, 2'(j), a};
      end
    end
    if (pd) for (int r = eff; r < 4; r++) for (int w = 0; w < 8; w++) exp_blk[r*8+w] = '0;
  endtask

  task automatic pulse_load(input logic [25:0] sa, input logic [9:0] st, input int nrows,
                            input logic pd);
    @(posedge clk); #1;
    start_address = sa; stride = st; rows = 10'(nrows); pad = pd; load_ddr = 1'b1;
    @(posedge clk); #1;
    load_ddr = 1'b0;
    // Scramble inputs: a latched load must not see these.
    start_address = 26'h155555; stride = 10'h3FF; rows = 10'd1; pad = ~pd;
  endtask

  task automatic do_load(input logic [25:0] sa, input logic [9:0] st, input int nrows,
                         input logic pd, input int wc, input int lat, input int poke);
    int eff, acc0, budget;
    wait_cycles = wc;
    latency = lat;
    build_model(sa, st, nrows, pd, eff);
    acc0 = accepted_cnt;
    pulse_load(sa, st, nrows, pd);
    budget = 0;
    while (!ready && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      load_ddr = (poke != 0 && budget == poke);
    end
    load_ddr = 1'b0;
    check("load completes", 64'(budget < 3000), 64'd1);
    check_block("block contents");
    check("command count", 64'(accepted_cnt - acc0), 64'(eff * 2));
    check("model queue drained", 64'(exp_addr_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] obs_at(input int k);
    return (k < obs_addr_q.size()) ? 64'(obs_addr_q[k]) : 64'hDEAD_BEEF_0000;
  endfunction

  // Avalon slave plus per-cycle compare against the model.
  always @(negedge clk) begin
    cyc++;
    if (ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
      avl_readdatavalid = 1'b1;
      avl_readdata      = beat_data(ret_addr_q[0]);
      void'(ret_due_q.pop_front());
      void'(ret_addr_q.pop_front());
      returned_cnt++;
      last_ret_cyc = cyc;
    end else begin
      avl_readdatavalid = 1'b0;
    end
    if (!reset) begin
      check("write tie-off", {63'b0, avl_write | (|avl_writedata)}, 64'd0);
      check("burstbegin with read", 64'(avl_burstbegin), 64'(avl_read));
      check("no read while ready", 64'(ready & avl_read), 64'd0);
      if (prev_wait && !clear) check("command held", {37'b0, avl_read, avl_address},
                                     {37'b0, 1'b1, prev_addr});
    end
    if (avl_read && !reset) begin
      if (wait_ctr < wait_cycles) begin
        avl_wait_request_n = 1'b0;
        wait_ctr++;
      end else begin
        avl_wait_request_n = 1'b1;
        wait_ctr = 0;
        accepted_cnt++;
        obs_addr_q.push_back(avl_address);
        ret_due_q.push_back(cyc + latency);
        ret_addr_q.push_back(avl_address);
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected command: got %0h, expected none", avl_address);
        end else begin
          checks--;
          check("command address", 64'(avl_address), 64'(exp_addr_q.pop_front()));
        end
      end
    end else begin
      avl_wait_request_n = 1'b1;
      wait_ctr = 0;
    end
    prev_wait = avl_read && !avl_wait_request_n && !reset;
    prev_addr = avl_address;
    if (accepted_cnt - returned_cnt > max_out) max_out = accepted_cnt - returned_cnt;
    if (!reset) check("outstanding bound", 64'(accepted_cnt - returned_cnt <= 4), 64'd1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int eff, acc0, ret0, budget;
    reset = 1'b1; clear = 1'b0; load_ddr = 1'b0; pad = 1'b0; local_init_done = 1'b1;
    start_address = '0; stride = '0; rows = '0;
    avl_wait_request_n = 1'b1; avl_readdatavalid = 1'b0; avl_readdata = '0;
    exp_blk = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset read", 64'(avl_read), 64'd0);
    check("reset burstbegin", 64'(avl_burstbegin), 64'd0);
    check("reset address", 64'(avl_address), 64'd0);
    check_block("reset block");
    reset = 1'b0;

    // Basic load, zero-wait slave, latency 2.
    do_load(26'h100, 10'h20, 4, 1'b0, 0, 2, 0);
    for (int k = 0; k < 8; k++) check("basic address", obs_at(k), 64'(lit_basic[k]));
    check("basic word0", 64'(block[0]), 64'hA000_0100);
    check("basic word5", 64'(block[5]), 64'hA400_0101);
    check("basic word8", 64'(block[8]), 64'hA000_0120);
    check("basic word31", 64'(block[31]), 64'hAC00_0161);

    // Pad on, two rows.
    do_load(26'h200, 10'h10, 2, 1'b1, 0, 2, 0);
    check("pad word0", 64'(block[0]), 64'hA000_0200);
    check("pad word16", 64'(block[16]), 64'd0);
    check("pad word31", 64'(block[31]), 64'd0);

    // Pad off: rows 2..3 keep the previous full load.
    do_load(26'h100, 10'h20, 4, 1'b0, 0, 2, 0);
    do_load(26'h300, 10'h40, 2, 1'b0, 0, 2, 0);
    check("nopad word0", 64'(block[0]), 64'hA000_0300);
    check("nopad word16", 64'(block[16]), 64'hA000_0140);

    // Backpressure: 5 wait cycles per command, latency 10.
    do_load(26'h1000, 10'h3, 4, 1'b0, 5, 10, 0);

    // Long latency: outstanding must reach but not pass the ceiling.
    max_out = 0;
    do_load(26'h2000, 10'h100, 4, 1'b0, 0, 12, 0);
    check("outstanding ceiling", 64'(max_out), 64'd4);

    // Address wrap at 2^26.
    do_load(26'h3FFFFFF, 10'h1, 2, 1'b1, 0, 2, 0);
    for (int k = 0; k < 4; k++) check("wrap address", obs_at(k), 64'(lit_wrap[k]));

    // Row count above MAX_ROWS is clamped.
    do_load(26'h40, 10'h8, 9, 1'b0, 0, 3, 0);
    check("clamped commands", 64'(obs_addr_q.size()), 64'd8);

    // load_ddr while busy is ignored.
    do_load(26'h500, 10'h10, 4, 1'b0, 1, 4, 3);

    // load_ddr without calibration is ignored.
    local_init_done = 1'b0;
    acc0 = accepted_cnt;
    exp_addr_q.delete();
    @(posedge clk); #1;
    load_ddr = 1'b1; start_address = 26'h77; stride = 10'h1; rows = 10'd4;
    @(posedge clk); #1;
    load_ddr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no-init ready", 64'(ready), 64'd1);
    check("no-init commands", 64'(accepted_cnt - acc0), 64'd0);
    local_init_done = 1'b1;

    // Zero rows with pad: whole block cleared, no commands.
    do_load(26'h7, 10'h1, 0, 1'b1, 0, 2, 0);

    // Clear in IDLE zeroes the block.
    do_load(26'h100, 10'h20, 4, 1'b0, 0, 2, 0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_blk = '0;
    check_block("idle clear");

    // Abort after 3 accepted / 1 returned.
    wait_cycles = 2;
    latency = 6;
    build_model(26'h800, 10'h10, 4, 1'b0, eff);
    acc0 = accepted_cnt;
    ret0 = returned_cnt;
    pulse_load(26'h800, 10'h10, 4, 1'b0);
    budget = 0;
    while (!(accepted_cnt - acc0 == 3 && returned_cnt - ret0 == 1) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("abort point reached", 64'(budget < 200), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    budget = 0;
    while (!ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain ready rise", 64'(cyc), 64'(last_ret_cyc));
    check("drain beats returned", 64'(returned_cnt - ret0), 64'd3);
    check("no commands after clear", 64'(accepted_cnt - acc0), 64'd3);
    exp_addr_q.delete();

    // Async reset mid-load.
    do_load(26'h100, 10'h20, 4, 1'b0, 0, 2, 0);
    wait_cycles = 0;
    latency = 2;
    build_model(26'hA00, 10'h4, 4, 1'b0, eff);
    pulse_load(26'hA00, 10'h4, 4, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_blk = '0;
    check("async reset ready", 64'(ready), 64'd1);
    check("async reset read", 64'(avl_read), 64'd0);
    check("async reset burstbegin", 64'(avl_burstbegin), 64'd0);
    check("async reset address", 64'(avl_address), 64'd0);
    check_block("async reset block");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_addr_q.delete();
    acc0 = accepted_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("post-reset ready", 64'(ready), 64'd1);
    check("post-reset commands", 64'(accepted_cnt - acc0), 64'd0);
    check_block("stale beats ignored");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
